dma_req_encoder: RTL and testbench
==================================

DMA_REQ_ENCODER -- requirements
Module: dma_req_encoder

Interface
REQ-001 Parameter TMO_CYC, default 255, number of BUSY cycles without done_i before timeout abort (range 1..255).
REQ-002 clk_i  input  1  single clock; all logic on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 en_i  input  1  enables new channel selection.
REQ-005 req_i  input  16  level DMA requests, bit n = channel n.
REQ-006 rdy_i  input  1  transfer engine accepts the offered channel.
REQ-007 done_i  input  1  one-cycle pulse; the engine finished the current channel.
REQ-008 vld_o  output  1  ch_o holds a valid offer.
REQ-009 ch_o  output  4  encoded channel index.
REQ-010 gnt_o  output  16  one-hot grant; only bit ch_o is set, and only while BUSY.
REQ-011 busy_o  output  1  high while in BUSY.
REQ-012 tmo_o  output  1  one-cycle pulse when a timeout abort occurs.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, OFFER, BUSY.
REQ-014 IDLE: when en_i=1 and req_i!=0, the encoded index SHALL be registered into ch_o, and the FSM SHALL enter OFFER; vld_o rises one cycle after req_i is sampled.
REQ-015 IDLE with en_i=0 or req_i=0: the FSM SHALL stay in IDLE, with vld_o=0.
REQ-016 OFFER: vld_o=1 and ch_o held stable; an offer is committed, so it is never withdrawn, even if req_i[ch_o] drops or en_i falls.
REQ-017 OFFER with rdy_i=1: the FSM SHALL enter BUSY next cycle, with vld_o=0 and gnt_o=1<<ch_o.
REQ-018 BUSY: busy_o=1 and the timeout counter increments each cycle from 0; req_i is ignored.
REQ-019 BUSY with done_i=1: the FSM SHALL return to IDLE next cycle, with gnt_o=0 and busy_o=0.
REQ-020 BUSY with counter==TMO_CYC-1 and done_i=0: tmo_o SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-021 When done_i and the timeout condition occur in the same cycle, done_i wins and tmo_o SHALL stay 0.
REQ-022 done_i and rdy_i SHALL be ignored in states where they have no meaning (done_i outside BUSY, rdy_i outside OFFER).
REQ-023 IDLE is re-entered for at least one cycle between grants, so back-to-back grants are spaced at a minimum of 3 cycles.
REQ-024 ch_o SHALL keep its last value in IDLE; vld_o qualifies it.

Reset
REQ-025 While rst_i=1 at a clock edge:
- state=IDLE
- vld_o=0
- ch_o=0
- gnt_o=0
- busy_o=0
- tmo_o=0
- timeout counter=0
- round-robin pointer=15
REQ-026 Reset asserted mid-OFFER or mid-BUSY SHALL abort with no tmo_o pulse; the engine treats the aborted grant as dropped.

Configuration
REQ-027 Macro DMA_REQ_ENCODER_ROUND_ROBIN_EN, when defined, SHALL select round-robin encoding:
- the search starts at pointer+1 and wraps modulo 16;
- the pointer loads ch_o on the OFFER->BUSY transition only.
REQ-028 When the macro is undefined, selection SHALL be fixed priority, where the lowest set index wins; the pointer SHALL not exist.

Structure
REQ-029 Shared package dma_pkg SHALL hold:
- CH_NUM=16
- CH_W=4
- the state enum typedef (IDLE, OFFER, BUSY)
REQ-030 Sub-module prio_enc_16to4 SHALL be combinational: inputs are a 16-bit vector and a 4-bit start index; outputs are a 4-bit index and an any-set flag. Fixed-priority mode ties the start index to 0.

Verification
REQ-031 Reset, then req_i=16'h0000, en_i=1 for 10 cycles -> vld_o=0, busy_o=0 throughout.
REQ-032 Fixed priority: req_i=16'h8024 -> vld_o=1, ch_o=2 one cycle later. Then rdy_i=1 -> gnt_o=16'h0004, busy_o=1. Then done_i -> IDLE, and the next offer is ch_o=2 again.
REQ-033 Round-robin: req_i=16'h8024 held, with rdy_i and done_i returned each grant -> ch_o sequence 2, 5, 15, 2.
REQ-034 Timeout: TMO_CYC=4, grant accepted, done_i never asserted -> tmo_o pulses exactly once 4 cycles after BUSY entry, then IDLE. Also: done_i in that same final cycle -> tmo_o stays 0.
REQ-035 Offer commitment: ch_o=5 offered, then req_i cleared and en_i=0 before rdy_i -> vld_o stays 1, ch_o=5. After rdy_i=1, gnt_o=16'h0020.
REQ-036 rst_i pulsed during BUSY -> next cycle all outputs are 0 and tmo_o=0; round-robin pointer=15 (next grant with req_i=16'hFFFF is ch_o=0).

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request encoder.
// Holds channel sizing, the FSM state type and a one-hot helper.
package dma_pkg;

   localparam int CH_NUM = 16;
   localparam int CH_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      BUSY  = 2'd2
   } state_e;

   function automatic logic [CH_NUM-1:0] ch_onehot(input logic [CH_W-1:0] ch);
      logic [CH_NUM-1:0] oh;
      oh = '0;
      oh[ch] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/prio_enc_16to4.sv
// Combinational 16-to-4 priority encoder with a rotating start index.
// The first set bit at or after start_i (wrapping modulo 16) wins.
module prio_enc_16to4
   import dma_pkg::*;
(
   input  logic [CH_NUM-1:0] vec_i,
   input  logic [CH_W-1:0]   start_i,
   output logic [CH_W-1:0]   idx_o,
   output logic              any_o
);

   logic [2*CH_NUM-1:0] dbl_vec;
   logic [CH_NUM-1:0]   rot_vec;
   logic [CH_W-1:0]     off;

   // Rotating right by start_i turns the wrapped search into a plain lowest-bit search.
   assign dbl_vec = {vec_i, vec_i};
   assign rot_vec = dbl_vec[start_i +: CH_NUM];

   always_comb begin
      off = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (rot_vec[i]) begin
            off = CH_W'(i);
         end
      end
   end

   assign idx_o = off + start_i;
   assign any_o = |vec_i;

endmodule

// File: rtl/dma_req_encoder.sv
// DMA request encoder: picks a requesting channel, offers it, grants it until done or timeout.
// Define DMA_REQ_ENCODER_ROUND_ROBIN_EN for round-robin selection; fixed priority otherwise.
module dma_req_encoder
   import dma_pkg::*;
#(
   parameter int unsigned TMO_CYC = 255
)
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [CH_NUM-1:0] req_i,
   input  logic              rdy_i,
   input  logic              done_i,
   output logic              vld_o,
   output logic [CH_W-1:0]   ch_o,
   output logic [CH_NUM-1:0] gnt_o,
   output logic              busy_o,
   output logic              tmo_o
);

   localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

   state_e          state_q, state_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            tmo_q, tmo_d;
   logic [CH_W-1:0] enc_start;
   logic [CH_W-1:0] enc_idx;
   logic            enc_any;

   prio_enc_16to4 u_prio_enc (
      .vec_i   (req_i),
      .start_i (enc_start),
      .idx_o   (enc_idx),
      .any_o   (enc_any)
   );

`ifdef DMA_REQ_ENCODER_ROUND_ROBIN_EN
   logic [CH_W-1:0] ptr_q, ptr_d;

   assign enc_start = ptr_q + 4'd1;

   // Pointer only advances once the engine has actually taken the channel.
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == OFFER && rdy_i) begin
         ptr_d = ch_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= 4'hF;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign enc_start = '0;
`endif

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (en_i && enc_any) begin
               ch_d    = enc_idx;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (rdy_i) begin
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // done_i takes precedence over an expiring timeout.
            if (done_i) begin
               state_d = IDLE;
            end else if (cnt_q == TMO_LAST) begin
               tmo_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ch_q    <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign vld_o  = (state_q == OFFER);
   assign busy_o = (state_q == BUSY);
   assign gnt_o  = (state_q == BUSY) ? ch_onehot(ch_q) : '0;
   assign ch_o   = ch_q;
   assign tmo_o  = tmo_q;

endmodule

// File: tb/tb_dma_req_encoder.sv
// Self-checking bench for dma_req_encoder with an expected-channel scoreboard.
// Honours DMA_REQ_ENCODER_ROUND_ROBIN_EN when computing expected channels.
module tb_dma_req_encoder;
   import dma_pkg::*;

   localparam int unsigned TMO = 4;

   logic              clk_i;
   logic              rst_i;
   logic              en_i;
   logic [CH_NUM-1:0] req_i;
   logic              rdy_i;
   logic              done_i;
   logic              vld_o;
   logic [CH_W-1:0]   ch_o;
   logic [CH_NUM-1:0] gnt_o;
   logic              busy_o;
   logic              tmo_o;

   int              checks;
   int              errors;
   int              lat;
   logic [CH_W-1:0] exp_q[$];
   logic [CH_W-1:0] mdl_ptr;
   logic [CH_W-1:0] cur_ch;

   dma_req_encoder #(.TMO_CYC(TMO)) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (en_i),
      .req_i  (req_i),
      .rdy_i  (rdy_i),
      .done_i (done_i),
      .vld_o  (vld_o),
      .ch_o   (ch_o),
      .gnt_o  (gnt_o),
      .busy_o (busy_o),
      .tmo_o  (tmo_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference selection: scan channels in order from the search start.
   function automatic logic [CH_W-1:0] mdl_pick(input logic [CH_NUM-1:0] req, input logic [CH_W-1:0] ptr);
      logic [CH_W-1:0] start;
      logic [CH_W-1:0] idx;
      logic [CH_W-1:0] pick;
`ifdef DMA_REQ_ENCODER_ROUND_ROBIN_EN
      start = ptr + 4'd1;
`else
      start = 4'd0;
      idx   = ptr;
`endif
      pick = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         idx = start + CH_W'(i);
         if (req[idx]) pick = idx;
      end
      return pick;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_offer(input logic [CH_NUM-1:0] req, input string tag);
      logic [CH_W-1:0] e;
      bit seen;
      req_i = req;
      en_i  = 1'b1;
      exp_q.push_back(mdl_pick(req, mdl_ptr));
      seen = 0;
      lat  = 0;
      for (int n = 1; n <= 6 && !seen; n++) begin
         tick();
         if (vld_o) begin
            seen = 1;
            lat  = n;
         end
      end
      check_val({tag, "_vld"}, 32'(vld_o), 32'd1);
      e      = exp_q.pop_front();
      cur_ch = e;
      check_val({tag, "_ch"}, 32'(ch_o), 32'(e));
      $display("offer  %-10s req=%04h ch=%0d exp=%0d lat=%0d", tag, req, ch_o, e, lat);
   endtask

   task automatic do_grant(input string tag);
      rdy_i = 1'b1;
      tick();
      rdy_i = 1'b0;
      check_val({tag, "_busy"}, 32'(busy_o), 32'd1);
      check_val({tag, "_vld_off"}, 32'(vld_o), 32'd0);
      check_val({tag, "_gnt"}, 32'(gnt_o), 32'(ch_onehot(cur_ch)));
      mdl_ptr = cur_ch;
      $display("grant  %-10s gnt=%04h", tag, gnt_o);
   endtask

   task automatic do_done(input string tag);
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      check_val({tag, "_done_busy"}, 32'(busy_o), 32'd0);
      check_val({tag, "_done_gnt"}, 32'(gnt_o), 32'd0);
      check_val({tag, "_done_tmo"}, 32'(tmo_o), 32'd0);
      $display("done   %-10s busy=%0d", tag, busy_o);
   endtask

   initial begin
      int pulses;
      int at;
      checks  = 0;
      errors  = 0;
      mdl_ptr = 4'hF;
      cur_ch  = '0;
      rst_i   = 1'b1;
      en_i    = 1'b0;
      req_i   = '0;
      rdy_i   = 1'b0;
      done_i  = 1'b0;

      tick();
      tick();
      check_val("rst_vld", 32'(vld_o), 32'd0);
      check_val("rst_ch", 32'(ch_o), 32'd0);
      check_val("rst_gnt", 32'(gnt_o), 32'd0);
      check_val("rst_busy", 32'(busy_o), 32'd0);
      check_val("rst_tmo", 32'(tmo_o), 32'd0);
      rst_i = 1'b0;
      $display("reset  released");

      // No requests: nothing may be offered.
      en_i  = 1'b1;
      req_i = '0;
      for (int n = 0; n < 10; n++) begin
         tick();
         check_val("noreq_vld", 32'(vld_o), 32'd0);
         check_val("noreq_busy", 32'(busy_o), 32'd0);
      end
      $display("idle   10 cycles with req=0");

      do_offer(16'h8024, "seq0");
      check_val("seq0_lat", 32'(lat), 32'd1);
      do_grant("seq0");
      do_done("seq0");
      for (int k = 1; k <= 3; k++) begin
         do_offer(16'h8024, $sformatf("seq%0d", k));
         check_val("seq_lat", 32'(lat), 32'd1);
         do_grant($sformatf("seq%0d", k));
         do_done($sformatf("seq%0d", k));
      end

      // Timeout with done_i never asserted.
      do_offer(16'h0010, "tmo");
      do_grant("tmo");
      en_i   = 1'b0;
      pulses = 0;
      at     = 0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (tmo_o) begin
            pulses++;
            if (at == 0) at = n;
         end
      end
      check_val("tmo_at", 32'(at), 32'd4);
      check_val("tmo_pulses", 32'(pulses), 32'd1);
      check_val("tmo_busy", 32'(busy_o), 32'd0);
      $display("tmo    pulses=%0d at=%0d", pulses, at);

      // done_i on the final timeout cycle must suppress tmo_o.
      do_offer(16'h0010, "tmo_done");
      do_grant("tmo_done");
      en_i = 1'b0;
      tick();
      tick();
      tick();
      check_val("tmo_done_busy_pre", 32'(busy_o), 32'd1);
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      check_val("tmo_done_tmo", 32'(tmo_o), 32'd0);
      check_val("tmo_done_busy", 32'(busy_o), 32'd0);
      tick();
      check_val("tmo_done_tmo2", 32'(tmo_o), 32'd0);
      $display("tmo    done on final cycle, tmo=%0d", tmo_o);

      // Committed offer survives request and enable withdrawal.
      do_offer(16'h0020, "commit");
      req_i = '0;
      en_i  = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         check_val("commit_vld", 32'(vld_o), 32'd1);
         check_val("commit_ch", 32'(ch_o), 32'd5);
      end
      do_grant("commit");
      check_val("commit_gnt", 32'(gnt_o), 32'h0020);
      do_done("commit");

      // rdy_i and done_i are meaningless in IDLE.
      rdy_i  = 1'b1;
      done_i = 1'b1;
      tick();
      rdy_i  = 1'b0;
      done_i = 1'b0;
      check_val("ign_vld", 32'(vld_o), 32'd0);
      check_val("ign_busy", 32'(busy_o), 32'd0);
      check_val("ign_tmo", 32'(tmo_o), 32'd0);
      $display("ignore rdy/done in IDLE");

      // Reset while BUSY aborts cleanly and rewinds the pointer.
      do_offer(16'hFFFF, "rst_busy");
      do_grant("rst_busy");
      en_i  = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      mdl_ptr = 4'hF;
      check_val("rstb_vld", 32'(vld_o), 32'd0);
      check_val("rstb_ch", 32'(ch_o), 32'd0);
      check_val("rstb_gnt", 32'(gnt_o), 32'd0);
      check_val("rstb_busy", 32'(busy_o), 32'd0);
      check_val("rstb_tmo", 32'(tmo_o), 32'd0);
      tick();
      check_val("rstb_tmo2", 32'(tmo_o), 32'd0);
      $display("reset  during BUSY");
      do_offer(16'hFFFF, "post_rst");
      do_grant("post_rst");
      do_done("post_rst");

      check_val("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
